// File: rtl/operand_net_iface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : operand_net_iface                                            |
// | Description : Tile <-> operand-router local-port interface. Stamps and     |
// |               injects flits with one-outstanding req/ack plus retry;       |
// |               queues ejected flits for the tile with overflow tracking.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module operand_net_iface #(
    parameter int FLIT_W    = 64,
    parameter int PRI_W     = 2,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tile_inj_valid,
    output logic              tile_inj_ready,
    input  logic [FLIT_W-1:0] tile_inj_flit,
    input  logic [PRI_W-1:0]  tile_inj_pri,
    output logic [FLIT_W-1:0] rtr_flit_in,
    output logic              rtr_req_in,
    input  logic              rtr_ack_out,
    input  logic [FLIT_W-1:0] rtr_flit_out,
    input  logic              rtr_req_out,
    output logic              tile_ej_valid,
    input  logic              tile_ej_ready,
    output logic [FLIT_W-1:0] tile_ej_flit,
    output logic              overflow_err,
    output logic [CNT_W-1:0]  retry_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int c_inj_aw = $clog2(INJ_DEPTH);
    localparam int c_ej_aw  = $clog2(EJ_DEPTH);

    localparam logic [c_inj_aw:0]   c_inj_full    = INJ_DEPTH[c_inj_aw:0];
    localparam logic [c_inj_aw:0]   c_inj_one     = 1;
    localparam logic [c_inj_aw-1:0] c_inj_ptr_one = 1;
    localparam logic [c_ej_aw:0]    c_ej_full     = EJ_DEPTH[c_ej_aw:0];
    localparam logic [c_ej_aw:0]    c_ej_one      = 1;
    localparam logic [c_ej_aw-1:0]  c_ej_ptr_one  = 1;
    localparam logic [CNT_W-1:0]    c_cnt_max     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_cnt_one     = 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    // ---------------- injection path ----------------
    logic [FLIT_W-1:0]   r_inj_mem [INJ_DEPTH];
    logic [c_inj_aw-1:0] r_inj_wr;
    logic [c_inj_aw-1:0] r_inj_rd;
    logic [c_inj_aw:0]   r_inj_cnt;
    logic [1:0]          r_state;
    logic                r_req_in;
    logic [FLIT_W-1:0]   r_flit_in;
    logic [CNT_W-1:0]    r_retry_cnt;

    logic                w_inj_full;
    logic                w_inj_push;
    logic                w_inj_pop;
    logic [c_inj_aw-1:0] w_inj_rd_nxt;
    logic [FLIT_W-1:0]   w_inj_stamped;
    logic                w_unused_pri;

    assign w_inj_full    = (r_inj_cnt == c_inj_full);
    assign w_inj_push    = tile_inj_valid && !w_inj_full;
    assign w_inj_pop     = (r_state == c_st_wait) && rtr_ack_out;
    assign w_inj_rd_nxt  = r_inj_rd + c_inj_ptr_one;
    assign w_inj_stamped = {tile_inj_pri, tile_inj_flit[FLIT_W-PRI_W-1:0]};
    // Priority bits from the tile are overwritten by tile_inj_pri.
    assign w_unused_pri  = ^tile_inj_flit[FLIT_W-1 -: PRI_W];

    always_ff @(posedge clk) begin
        if (w_inj_push) begin
            r_inj_mem[r_inj_wr] <= w_inj_stamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_wr    <= '0;
            r_inj_rd    <= '0;
            r_inj_cnt   <= '0;
            r_state     <= c_st_idle;
            r_req_in    <= 1'b0;
            r_flit_in   <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_inj_push) begin
                r_inj_wr <= r_inj_wr + c_inj_ptr_one;
            end
            if (w_inj_pop) begin
                r_inj_rd <= w_inj_rd_nxt;
            end
            case ({w_inj_push, w_inj_pop})
                2'b10:   r_inj_cnt <= r_inj_cnt + c_inj_one;
                2'b01:   r_inj_cnt <= r_inj_cnt - c_inj_one;
                default: r_inj_cnt <= r_inj_cnt;
            endcase

            case (r_state)
                c_st_idle: begin
                    if (r_inj_cnt != '0) begin
                        r_state   <= c_st_send;
                        r_req_in  <= 1'b1;
                        r_flit_in <= r_inj_mem[r_inj_rd];
                    end
                end
                c_st_send: begin
                    r_state  <= c_st_wait;
                    r_req_in <= 1'b0;
                end
                c_st_wait: begin
                    if (rtr_ack_out) begin
                        // Head is retired this cycle; chain straight into the next one.
                        if (r_inj_cnt > c_inj_one) begin
                            r_state   <= c_st_send;
                            r_req_in  <= 1'b1;
                            r_flit_in <= r_inj_mem[w_inj_rd_nxt];
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_state  <= c_st_send;
                        r_req_in <= 1'b1;
                        if (r_retry_cnt != c_cnt_max) begin
                            r_retry_cnt <= r_retry_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_req_in <= 1'b0;
                end
            endcase
        end
    end

    assign tile_inj_ready = !w_inj_full;
    assign rtr_req_in     = r_req_in;
    assign rtr_flit_in    = r_flit_in;
    assign retry_cnt      = r_retry_cnt;

    // ---------------- ejection path ----------------
    logic [FLIT_W-1:0]  r_ej_mem [EJ_DEPTH];
    logic [c_ej_aw-1:0] r_ej_wr;
    logic [c_ej_aw-1:0] r_ej_rd;
    logic [c_ej_aw:0]   r_ej_cnt;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic w_ej_full;
    logic w_ej_pop;
    logic w_ej_push;
    logic w_ej_drop;

    assign w_ej_full = (r_ej_cnt == c_ej_full);
    assign w_ej_pop  = (r_ej_cnt != '0) && tile_ej_ready;
    // A pop in the same cycle frees the slot the incoming flit lands in.
    assign w_ej_push = rtr_req_out && (!w_ej_full || w_ej_pop);
    assign w_ej_drop = rtr_req_out && w_ej_full && !w_ej_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EJ_DEPTH; i++) begin
                r_ej_mem[i] <= '0;
            end
        end else if (w_ej_push) begin
            r_ej_mem[r_ej_wr] <= rtr_flit_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ej_wr    <= '0;
            r_ej_rd    <= '0;
            r_ej_cnt   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_ej_push) begin
                r_ej_wr <= r_ej_wr + c_ej_ptr_one;
            end
            if (w_ej_pop) begin
                r_ej_rd <= r_ej_rd + c_ej_ptr_one;
            end
            case ({w_ej_push, w_ej_pop})
                2'b10:   r_ej_cnt <= r_ej_cnt + c_ej_one;
                2'b01:   r_ej_cnt <= r_ej_cnt - c_ej_one;
                default: r_ej_cnt <= r_ej_cnt;
            endcase
            if (w_ej_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_cnt_max) begin
                    r_drop_cnt <= r_drop_cnt + c_cnt_one;
                end
            end
        end
    end

    assign tile_ej_valid = (r_ej_cnt != '0);
    assign tile_ej_flit  = r_ej_mem[r_ej_rd];
    assign overflow_err  = r_overflow;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_net_iface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_operand_net_iface                                         |
// | Description : Directed + randomized bench for operand_net_iface against a  |
// |               queue-based reference model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_operand_net_iface;

    localparam int FW    = 64;
    localparam int PW    = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tile_inj_valid = 1'b0;
    logic          tile_inj_ready;
    logic [FW-1:0] tile_inj_flit = '0;
    logic [PW-1:0] tile_inj_pri = '0;
    logic [FW-1:0] rtr_flit_in;
    logic          rtr_req_in;
    logic          rtr_ack_out = 1'b0;
    logic [FW-1:0] rtr_flit_out = '0;
    logic          rtr_req_out = 1'b0;
    logic          tile_ej_valid;
    logic          tile_ej_ready = 1'b0;
    logic [FW-1:0] tile_ej_flit;
    logic          overflow_err;
    logic [CW-1:0] retry_cnt;
    logic [CW-1:0] drop_cnt;

    operand_net_iface #(
        .FLIT_W(FW), .PRI_W(PW), .INJ_DEPTH(DEPTH), .EJ_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .tile_inj_valid(tile_inj_valid), .tile_inj_ready(tile_inj_ready),
        .tile_inj_flit(tile_inj_flit), .tile_inj_pri(tile_inj_pri),
        .rtr_flit_in(rtr_flit_in), .rtr_req_in(rtr_req_in), .rtr_ack_out(rtr_ack_out),
        .rtr_flit_out(rtr_flit_out), .rtr_req_out(rtr_req_out),
        .tile_ej_valid(tile_ej_valid), .tile_ej_ready(tile_ej_ready),
        .tile_ej_flit(tile_ej_flit), .overflow_err(overflow_err),
        .retry_cnt(retry_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_sends  = 0;

    // Reference model: FIFO contents as queues, handshake phase as two flags.
    logic [FW-1:0] inj_q[$];
    logic [FW-1:0] ej_q[$];
    logic m_req      = 1'b0;
    logic m_prev_req = 1'b0;
    logic m_ovf      = 1'b0;
    int   m_retry    = 0;
    int   m_drop     = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        if (rtr_req_in === 1'b1) n_sends++;
        chk("req_in", {63'd0, rtr_req_in}, {63'd0, m_req});
        if ((m_req || m_prev_req) && inj_q.size() > 0)
            chk("flit_in", rtr_flit_in, inj_q[0]);
        chk("inj_ready", {63'd0, tile_inj_ready}, {63'd0, inj_q.size() < DEPTH});
        chk("ej_valid", {63'd0, tile_ej_valid}, {63'd0, ej_q.size() > 0});
        if (ej_q.size() > 0)
            chk("ej_flit", tile_ej_flit, ej_q[0]);
        chk("overflow", {63'd0, overflow_err}, {63'd0, m_ovf});
        chk("retry_cnt", {56'd0, retry_cnt}, {56'd0, CW'(m_retry)});
        chk("drop_cnt", {56'd0, drop_cnt}, {56'd0, CW'(m_drop)});
    endtask

    // One clock: check current outputs, drive inputs, advance the model, step.
    task automatic cyc(input logic iv, input logic [FW-1:0] iflit, input logic [PW-1:0] ipri,
                       input logic ack, input logic rq, input logic [FW-1:0] rflit,
                       input logic er);
        int sz;
        int rem;
        logic in_wait;
        check_outputs();
        tile_inj_valid = iv;
        tile_inj_flit  = iflit;
        tile_inj_pri   = ipri;
        rtr_ack_out    = ack;
        rtr_req_out    = rq;
        rtr_flit_out   = rflit;
        tile_ej_ready  = er;

        sz      = inj_q.size();
        in_wait = m_prev_req;
        rem     = sz;
        if (in_wait && ack) begin
            void'(inj_q.pop_front());
            rem = sz - 1;
        end
        if (in_wait && !ack && m_retry < CMAX) m_retry++;
        if (iv && sz < DEPTH) inj_q.push_back({ipri, iflit[FW-PW-1:0]});
        m_prev_req = m_req;
        m_req      = !m_req && (rem > 0);

        if (er && ej_q.size() > 0) void'(ej_q.pop_front());
        if (rq) begin
            if (ej_q.size() < DEPTH) ej_q.push_back(rflit);
            else begin
                m_ovf = 1'b1;
                if (m_drop < CMAX) m_drop++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tile_inj_valid = 1'b0;
        rtr_ack_out    = 1'b0;
        rtr_req_out    = 1'b0;
        tile_ej_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req_in", {63'd0, rtr_req_in}, 64'd0);
        chk("rst_flit_in", rtr_flit_in, 64'd0);
        chk("rst_ej_valid", {63'd0, tile_ej_valid}, 64'd0);
        chk("rst_ej_flit", tile_ej_flit, 64'd0);
        chk("rst_inj_ready", {63'd0, tile_inj_ready}, 64'd1);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        chk("rst_retry", {56'd0, retry_cnt}, 64'd0);
        chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
        inj_q.delete();
        ej_q.delete();
        m_req = 1'b0;
        m_prev_req = 1'b0;
        m_ovf = 1'b0;
        m_retry = 0;
        m_drop = 0;
        rst = 1'b0;
    endtask

    function automatic logic [FW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int naks;
        int sends0;
        logic a;
        #1;
        do_reset();

        // Single injection, ack always high (spurious acks outside WAIT ignored).
        sends0 = n_sends;
        cyc(1'b1, 64'h1234, 2'd1, 1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("single_flit_in", rtr_flit_in, 64'h4000_0000_0000_1234);
        repeat (5) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("single_sends", 64'(n_sends - sends0), 64'd1);
        chk("single_retry", {56'd0, retry_cnt}, 64'd0);

        // Three NAKs then an ack.
        naks = 0;
        sends0 = n_sends;
        cyc(1'b1, rnd64(), 2'd2, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            a = m_prev_req && (naks == 3);
            if (m_prev_req && naks < 3) naks++;
            cyc(1'b0, '0, '0, a, 1'b0, '0, 1'b1);
        end
        chk("retry_sends", 64'(n_sends - sends0), 64'd4);
        chk("retry3", {56'd0, retry_cnt}, 64'd3);

        // Injection backpressure: five offers, acks withheld, then drain.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, rnd64(), PW'($urandom), 1'b0, 1'b0, '0, 1'b1);
        chk("bp_ready_low", {63'd0, tile_inj_ready}, 64'd0);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        repeat (20) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("bp_ready_back", {63'd0, tile_inj_ready}, 64'd1);

        // Ejection burst of six with the tile stalled.
        for (int k = 1; k <= 6; k++)
            cyc(1'b0, '0, '0, 1'b0, 1'b1, 64'(k), 1'b0);
        chk("burst_ovf", {63'd0, overflow_err}, 64'd1);
        chk("burst_drop", {56'd0, drop_cnt}, 64'd2);
        chk("burst_head", tile_ej_flit, 64'd1);
        repeat (5) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Full FIFO with push and pop in the same cycle.
        for (int k = 11; k <= 14; k++)
            cyc(1'b0, '0, '0, 1'b0, 1'b1, 64'(k), 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 64'd15, 1'b1);
        chk("fullpop_drop", {56'd0, drop_cnt}, 64'd2);
        chk("fullpop_head", tile_ej_flit, 64'd12);
        repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Reset while waiting for an ack, then a stray ack.
        cyc(1'b1, rnd64(), 2'd3, 1'b0, 1'b1, rnd64(), 1'b0);
        cyc(1'b1, rnd64(), 2'd0, 1'b0, 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < 10 && !m_prev_req; i++)
            cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        do_reset();
        cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("late_ack_retry", {56'd0, retry_cnt}, 64'd0);
        chk("late_ack_req", {63'd0, rtr_req_in}, 64'd0);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Randomized traffic: heavy congestion first to reach counter saturation.
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 1) == 1, rnd64(), PW'($urandom),
                m_prev_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0),
                $urandom_range(0, 1) == 1, rnd64(), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, rnd64(), PW'($urandom),
                m_prev_req ? ($urandom_range(0, 3) != 0) : 1'b0,
                $urandom_range(0, 2) == 0, rnd64(), $urandom_range(0, 3) != 0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_net_iface.md
Name: operand_net_iface

Overview:
- Local-port network interface between an execution tile and its operand-network router (FLIT_TYPE=0).
- Injection path: buffers tile-produced operand flits, stamps the routing priority, and injects them into the router local input with a one-outstanding req/ack protocol plus retry.
- Ejection path: captures every flit the router delivers on its local output. The router local output has no backpressure, so the block always accepts. It queues flits for the tile on a valid/ready interface and flags overflow.

Parameters:
- FLIT_W, 64, total flit width (priority + dest_instr + payload).
- PRI_W, 2, width of priority field, located at flit MSBs [FLIT_W-1 -: PRI_W].
- INJ_DEPTH, 4, injection FIFO entries (power of 2, >=2).
- EJ_DEPTH, 4, ejection FIFO entries (power of 2, >=2).
- CNT_W, 8, width of saturating perf counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tile_inj_valid  in  1  tile offers flit
- tile_inj_ready  out  1  injection FIFO not full
- tile_inj_flit  in  FLIT_W  flit from tile; priority bits ignored
- tile_inj_pri  in  PRI_W  priority to stamp
- rtr_flit_in  out  FLIT_W  to router local flit_in
- rtr_req_in  out  1  to router local req_in
- rtr_ack_out  in  1  router local ack_out; registered, high at t+1 iff flit accepted at t
- rtr_flit_out  in  FLIT_W  router local flit_out
- rtr_req_out  in  1  router local req_out; one flit per high cycle
- tile_ej_valid  out  1  ejection FIFO not empty
- tile_ej_ready  in  1  tile consumes head
- tile_ej_flit  out  FLIT_W  ejection FIFO head
- overflow_err  out  1  sticky: ejected flit dropped
- retry_cnt  out  CNT_W  saturating count of injection retries
- drop_cnt  out  CNT_W  saturating count of dropped ejected flits

Behaviour:
- Reset: all FIFOs empty, pointers 0, FSM IDLE. Reset values: rtr_req_in=0, rtr_flit_in=0, tile_ej_valid=0, tile_ej_flit=0, tile_inj_ready=1, overflow_err=0, retry_cnt=0, drop_cnt=0.
  - Reset mid-operation discards all buffered and in-flight flits.
  - An ack arriving in the cycle after reset deasserts is ignored.
- Injection FIFO:
  - Push when tile_inj_valid && tile_inj_ready.
  - Stored flit = {tile_inj_pri, tile_inj_flit[FLIT_W-PRI_W-1:0]}.
  - tile_inj_ready = !full. Full = count==INJ_DEPTH; the pop in the same cycle does not free a slot for that cycle's push (ready is registered-state based).
  - Pointers wrap modulo depth; count is log2(depth)+1 bits.
- Injection FSM (one flit outstanding):
  - IDLE: if FIFO not empty -> SEND.
  - SEND: rtr_req_in=1 for exactly one cycle; rtr_flit_in = FIFO head (registered, stable from SEND through WAIT) -> WAIT.
  - WAIT: rtr_req_in=0.
    - rtr_ack_out=1: pop head; next state SEND if more than one entry remains, else IDLE.
    - rtr_ack_out=0: router was full; retry_cnt++ (saturating) -> SEND with the same flit.
  - Peak throughput is one flit per 2 cycles. The ack latency is exactly one cycle, so duplicate capture cannot occur.
  - rtr_ack_out outside WAIT is ignored.
- Ejection FIFO:
  - Push when rtr_req_out=1.
  - Pop when tile_ej_valid && tile_ej_ready.
  - tile_ej_flit is the registered head, valid when tile_ej_valid.
  - Full with simultaneous pop: the push succeeds (pop-then-push); count is unchanged.
  - Full without pop and rtr_req_out=1: flit dropped, overflow_err set (held until rst), drop_cnt++ (saturating at 2^CNT_W-1).
  - Empty with push: tile_ej_valid rises the following cycle; no bypass.
- Counters hold at max; they never wrap.

Test Plan:
- Reset then single injection:
  - Stimulus: flit 0x1234 with pri=1; ack given at WAIT.
  - Response: rtr_req_in high exactly one cycle, rtr_flit_in=0x4000_..._1234 (pri in MSBs), FIFO empty 2 cycles after SEND, retry_cnt=0.
- Retry:
  - Stimulus: withhold ack 3 times, then ack.
  - Response: 4 SEND pulses carrying the same flit, retry_cnt=3, one pop only.
- Injection backpressure:
  - Stimulus: push 4 flits back-to-back with INJ_DEPTH=4 and acks withheld.
  - Response: tile_inj_ready=0 after the 4th push; after the first ack, ready returns to 1 and the next flit is injected in order.
- Ejection burst:
  - Stimulus: rtr_req_out high 6 consecutive cycles with flits 1..6, tile_ej_ready=0.
  - Response: flits 1..4 queued, overflow_err=1, drop_cnt=2. Then with ready=1, tile receives 1,2,3,4 in order.
- Full-and-pop same cycle:
  - Stimulus: FIFO full, rtr_req_out=1 and tile_ej_ready=1 in the same cycle.
  - Response: no drop, count stays 4, the new flit appears last.
- Mid-operation reset:
  - Stimulus: assert rst during WAIT with both FIFOs non-empty.
  - Response: next cycle all outputs at reset values; a late ack causes no pop and no counter change.
